ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 212 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a five-stage pipeline.
// The ALU covers AND, OR, ADD, SUB, SLT, NOR and MUL, and its result is registered.
// Opcodes that the ALU does not support give a result of 0.
// Optional feature macro: EX_MUL_EN.
//   - When defined, an iterative shift-add multiplier is present.
//   - It takes 33 edges and raises Stall_Out while it works.
//   - Without the macro, opcode 1000 is treated as unsupported.
module ex_stage (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] ReadData1_In,
    input  logic [31:0] ReadData2_In,
    input  logic [31:0] Imm_In,
    input  logic        ALUSrc_In,
    input  logic [3:0]  ALUControl_In,
    input  logic [4:0]  Rd_In,
    input  logic [1:0]  MEMControl_In,
    input  logic [1:0]  WBControl_In,
    input  logic        Valid_In,
    output logic [31:0] ALUResult_Out,
    output logic [31:0] WriteData_Out,
    output logic [1:0]  MEMControl_Out,
    output logic [1:0]  WBControl_Out,
    output logic [4:0]  Rd_Out,
    output logic        Zero_Out,
    output logic        Valid_Out,
    output logic        Stall_Out
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef EX_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;

    // Operand B is selected between the register file and the immediate.
    always_comb begin
        op_a = ReadData1_In;
        op_b = ALUSrc_In ? Imm_In : ReadData2_In;
    end

    // Single-cycle ALU. MUL and unsupported codes fall to the default case and give 0.
    always_comb begin
        alu_result = '0;
        case (ALUControl_In)
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            OP_NOR:  alu_result = ~(op_a | op_b);
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [1:0]  mem_q;
    logic [1:0]  wb_q;
    logic        mul_start;
    logic [31:0] acc_next;

    // A MUL is accepted in IDLE. Each BUSY edge adds in the current partial product.
    // Stall_Out is forced low while reset is asserted, so upstream never waits during reset.
    always_comb begin
        mul_start = (state == IDLE) && Valid_In && (ALUControl_In == OP_MUL);
        acc_next  = acc + (mplier[0] ? mcand : 32'd0);
        Stall_Out = Rst_n && (mul_start || ((state == BUSY) && (count != 5'd31)));
    end

    // The multiply FSM and the pipeline output registers share one sequential process.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= IDLE;
            count          <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
            ALUResult_Out  <= '0;
            WriteData_Out  <= '0;
            MEMControl_Out <= '0;
            WBControl_Out  <= '0;
            Rd_Out         <= '0;
            Zero_Out       <= 1'b0;
            Valid_Out      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand          <= op_a;
                        mplier         <= op_b;
                        acc            <= '0;
                        wdata_q        <= ReadData2_In;
                        rd_q           <= Rd_In;
                        mem_q          <= MEMControl_In;
                        wb_q           <= WBControl_In;
                        count          <= '0;
                        state          <= BUSY;
                        ALUResult_Out  <= '0;
                        WriteData_Out  <= '0;
                        MEMControl_Out <= '0;
                        WBControl_Out  <= '0;
                        Rd_Out         <= '0;
                        Zero_Out       <= 1'b0;
                        Valid_Out      <= 1'b0;
                    end else if (Valid_In) begin
                        ALUResult_Out  <= alu_result;
                        WriteData_Out  <= ReadData2_In;
                        MEMControl_Out <= MEMControl_In;
                        WBControl_Out  <= WBControl_In;
                        Rd_Out         <= Rd_In;
                        Zero_Out       <= (alu_result == 32'd0);
                        Valid_Out      <= 1'b1;
                    end else begin
                        ALUResult_Out  <= '0;
                        WriteData_Out  <= '0;
                        MEMControl_Out <= '0;
                        WBControl_Out  <= '0;
                        Rd_Out         <= '0;
                        Zero_Out       <= 1'b0;
                        Valid_Out      <= 1'b0;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (count == 5'd31) begin
                        // The 32nd iteration completes on this edge.
                        // The combinational sum is loaded directly, so no extra edge is needed.
                        count          <= '0;
                        state          <= IDLE;
                        ALUResult_Out  <= acc_next;
                        WriteData_Out  <= wdata_q;
                        MEMControl_Out <= mem_q;
                        WBControl_Out  <= wb_q;
                        Rd_Out         <= rd_q;
                        Zero_Out       <= (acc_next == 32'd0);
                        Valid_Out      <= 1'b1;
                    end else begin
                        count          <= count + 5'd1;
                        ALUResult_Out  <= '0;
                        WriteData_Out  <= '0;
                        MEMControl_Out <= '0;
                        WBControl_Out  <= '0;
                        Rd_Out         <= '0;
                        Zero_Out       <= 1'b0;
                        Valid_Out      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Without the multiplier, nothing ever needs to stall.
    always_comb begin
        Stall_Out = 1'b0;
    end

    // Pipeline output registers.
    // They capture the instruction when Valid_In is high and load a bubble otherwise.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ALUResult_Out  <= '0;
            WriteData_Out  <= '0;
            MEMControl_Out <= '0;
            WBControl_Out  <= '0;
            Rd_Out         <= '0;
            Zero_Out       <= 1'b0;
            Valid_Out      <= 1'b0;
        end else if (Valid_In) begin
            ALUResult_Out  <= alu_result;
            WriteData_Out  <= ReadData2_In;
            MEMControl_Out <= MEMControl_In;
            WBControl_Out  <= WBControl_In;
            Rd_Out         <= Rd_In;
            Zero_Out       <= (alu_result == 32'd0);
            Valid_Out      <= 1'b1;
        end else begin
            ALUResult_Out  <= '0;
            WriteData_Out  <= '0;
            MEMControl_Out <= '0;
            WBControl_Out  <= '0;
            Rd_Out         <= '0;
            Zero_Out       <= 1'b0;
            Valid_Out      <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage.
// It covers the single-cycle ALU ops, bubbles, and reset.
// The multiplier is exercised when the design is built with EX_MUL_EN.
module tb_ex_stage;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] ReadData1_In;
    logic [31:0] ReadData2_In;
    logic [31:0] Imm_In;
    logic        ALUSrc_In;
    logic [3:0]  ALUControl_In;
    logic [4:0]  Rd_In;
    logic [1:0]  MEMControl_In;
    logic [1:0]  WBControl_In;
    logic        Valid_In;
    logic [31:0] ALUResult_Out;
    logic [31:0] WriteData_Out;
    logic [1:0]  MEMControl_Out;
    logic [1:0]  WBControl_Out;
    logic [4:0]  Rd_Out;
    logic        Zero_Out;
    logic        Valid_Out;
    logic        Stall_Out;

    int unsigned passed;
    int unsigned total;

    ex_stage dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ReadData1_In   (ReadData1_In),
        .ReadData2_In   (ReadData2_In),
        .Imm_In         (Imm_In),
        .ALUSrc_In      (ALUSrc_In),
        .ALUControl_In  (ALUControl_In),
        .Rd_In          (Rd_In),
        .MEMControl_In  (MEMControl_In),
        .WBControl_In   (WBControl_In),
        .Valid_In       (Valid_In),
        .ALUResult_Out  (ALUResult_Out),
        .WriteData_Out  (WriteData_Out),
        .MEMControl_Out (MEMControl_Out),
        .WBControl_Out  (WBControl_Out),
        .Rd_Out         (Rd_Out),
        .Zero_Out       (Zero_Out),
        .Valid_Out      (Valid_Out),
        .Stall_Out      (Stall_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic [1:0] mem, input logic [1:0] wb, input logic v);
        ALUControl_In = op;
        ReadData1_In  = a;
        ReadData2_In  = b;
        Imm_In        = imm;
        ALUSrc_In     = src;
        Rd_In         = rd;
        MEMControl_In = mem;
        WBControl_In  = wb;
        Valid_In      = v;
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_res"},   ALUResult_Out, 32'd0);
        chk({tag, "_wd"},    WriteData_Out, 32'd0);
        chk({tag, "_ctl"},   {26'd0, MEMControl_Out, WBControl_Out, Zero_Out, Valid_Out}, 32'd0);
        chk({tag, "_rd"},    {27'd0, Rd_Out}, 32'd0);
    endtask

`ifdef EX_MUL_EN
    // Runs one MUL from IDLE. After E0 the inputs are scrambled, which must not
    // disturb the operation in progress. The task returns just after E32.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] exp);
        int unsigned stall_cycles;
        int unsigned bad;
        stall_cycles = 0;
        bad = 0;
        drive(4'b1000, a, b, 32'h0000_0055, 1'b0, rd, 2'b10, 2'b01, 1'b1);
        #1;
        chk({tag, "_stall_comb"}, {31'd0, Stall_Out}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (!Stall_Out) break;
            stall_cycles++;
            step();
            if (Valid_Out !== 1'b0 || ALUResult_Out !== 32'd0) bad++;
            if (i == 0) drive(4'b0010, 32'd1, 32'd1, 32'd0, 1'b0, 5'd3, 2'b01, 2'b10, 1'b1);
        end
        chk({tag, "_stall_cycles"}, stall_cycles, 32'd32);
        chk({tag, "_busy_bubbles"}, bad, 32'd0);
        step();
        chk({tag, "_res"},   ALUResult_Out, exp);
        chk({tag, "_rd"},    {27'd0, Rd_Out}, {27'd0, rd});
        chk({tag, "_valid"}, {31'd0, Valid_Out}, 32'd1);
        chk({tag, "_mem"},   {30'd0, MEMControl_Out}, 32'd2);
        chk({tag, "_wb"},    {30'd0, WBControl_Out}, 32'd1);
        chk({tag, "_wd"},    WriteData_Out, b);
        chk({tag, "_zero"},  {31'd0, Zero_Out}, 32'd0);
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        Rst_n  = 1'b0;
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0);

        // Reset state.
        #3;
        chk_bubble("reset");
        chk("reset_stall", {31'd0, Stall_Out}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // ADD 5 + 7.
        drive(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 2'b00, 2'b11, 1'b1);
        step();
        chk("add_res",   ALUResult_Out, 32'd12);
        chk("add_zero",  {31'd0, Zero_Out}, 32'd0);
        chk("add_valid", {31'd0, Valid_Out}, 32'd1);
        chk("add_rd",    {27'd0, Rd_Out}, 32'd4);
        chk("add_wb",    {30'd0, WBControl_Out}, 32'd3);

        // SUB 9 - Imm 9.
        drive(4'b0110, 32'd9, 32'hDEAD_BEEF, 32'd9, 1'b1, 5'd2, 2'b01, 2'b00, 1'b1);
        step();
        chk("sub_res",  ALUResult_Out, 32'd0);
        chk("sub_zero", {31'd0, Zero_Out}, 32'd1);
        chk("sub_mem",  {30'd0, MEMControl_Out}, 32'd1);
        chk("sub_wd",   WriteData_Out, 32'hDEAD_BEEF);

        // Signed SLT in both directions.
        drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1, 2'b00, 2'b00, 1'b1);
        step();
        chk("slt_neg_lt_pos", ALUResult_Out, 32'd1);
        drive(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd1, 2'b00, 2'b00, 1'b1);
        step();
        chk("slt_pos_lt_neg", ALUResult_Out, 32'd0);
        chk("slt_zero",       {31'd0, Zero_Out}, 32'd1);

        // Logic ops.
        drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 5'd5, 2'b00, 2'b00, 1'b1);
        step();
        chk("and_res", ALUResult_Out, 32'hF000_F000);
        drive(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 5'd5, 2'b00, 2'b00, 1'b1);
        step();
        chk("or_res", ALUResult_Out, 32'hFFF0_FFF0);
        drive(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 5'd5, 2'b00, 2'b00, 1'b1);
        step();
        chk("nor_res", ALUResult_Out, 32'h000F_000F);

        // ADD wraps modulo 2^32.
        drive(4'b0010, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd6, 2'b00, 2'b00, 1'b1);
        step();
        chk("add_wrap_res",  ALUResult_Out, 32'd0);
        chk("add_wrap_zero", {31'd0, Zero_Out}, 32'd1);

        // An unsupported code gives result 0, but the controls still pass through.
        drive(4'b0011, 32'd8, 32'd9, 32'd0, 1'b0, 5'd17, 2'b10, 2'b01, 1'b1);
        step();
        chk("unsup_res",   ALUResult_Out, 32'd0);
        chk("unsup_valid", {31'd0, Valid_Out}, 32'd1);
        chk("unsup_rd",    {27'd0, Rd_Out}, 32'd17);
        chk("unsup_mem",   {30'd0, MEMControl_Out}, 32'd2);

        // A bubble clears every output.
        drive(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 5'd9, 2'b11, 2'b11, 1'b0);
        step();
        chk_bubble("bubble");

`ifdef EX_MUL_EN
        run_mul("mul1", 32'h0001_0001, 32'h0000_0003, 5'd7, 32'h0003_0003);
        // Back-to-back MUL, accepted in the IDLE edge right after E32.
        run_mul("mul2", 32'd6, 32'd7, 5'd9, 32'd42);

        // Reset asserted mid-MUL at count 10.
        drive(4'b1000, 32'd123, 32'd456, 32'd0, 1'b0, 5'd11, 2'b00, 2'b00, 1'b1);
        step();
        repeat (10) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rstmul_stall", {31'd0, Stall_Out}, 32'd0);
        chk_bubble("rstmul");
`else
        // Opcode 1000 behaves as unsupported.
        drive(4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 5'd8, 2'b00, 2'b00, 1'b1);
        #1;
        chk("nomul_stall", {31'd0, Stall_Out}, 32'd0);
        step();
        chk("nomul_res",   ALUResult_Out, 32'd0);
        chk("nomul_valid", {31'd0, Valid_Out}, 32'd1);
        chk("nomul_zero",  {31'd0, Zero_Out}, 32'd1);

        // Reset asserted between edges.
        #2;
        Rst_n = 1'b0;
        #1;
        chk_bubble("rst_async");
`endif

        // The first ADD after reset completes normally.
        drive(4'b0010, 32'd2, 32'd2, 32'd0, 1'b0, 5'd12, 2'b00, 2'b01, 1'b1);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        chk("post_rst_add_res",   ALUResult_Out, 32'd4);
        chk("post_rst_add_valid", {31'd0, Valid_Out}, 32'd1);
        chk("post_rst_add_rd",    {27'd0, Rd_Out}, 32'd12);
        chk("post_rst_stall",     {31'd0, Stall_Out}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
